// File: rtl/scope_pkg.sv
// scope_pkg: shared state encodings and trigger-edge codes for the scope capture block
package scope_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;
    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port sample memory with a registered read port
module sample_ram #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_SIZE-1:0] din,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_SIZE-1:0] dout
);
    logic [DATA_SIZE-1:0] mem [2**ADDR_W];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    // registered read port; output register clears on reset
    always_ff @(posedge clk) begin
        if (!rstn) dout <= '0;
        else       dout <= mem[raddr];
    end
endmodule

// File: rtl/scope_capture.sv
// scope_capture: triggered acquisition of one frame with pre-trigger history into a circular RAM
module scope_capture
    import scope_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_SIZE-1:0]  in_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic                  trig_edge,
    input  logic [DATA_SIZE-1:0]  trig_level,
    input  logic [DEPTH_LOG2-1:0] pretrig,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_SIZE-1:0]  rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  capture_done,
    output logic [DEPTH_LOG2-1:0] frame_start
);
    localparam logic [DEPTH_LOG2-1:0] ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] LAST = '1;

    state_t                state, state_n;
    logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_n, cnt, cnt_n, pretrig_q, pretrig_n, frame_start_n;
    logic [DATA_SIZE-1:0]  prev, prev_n, level_q, level_n;
    logic                  edge_q, edge_n, prev_valid, prev_valid_n, force_pend, force_pend_n, triggered_n;
    logic                  accept, crossed, hit;
    logic [DEPTH_LOG2-1:0] rd_phys;

    assign busy         = state inside {ST_PREFILL, ST_WAIT_TRIG, ST_POST};
    assign capture_done = state == ST_DONE;
    assign accept       = in_valid && busy;
    assign crossed      = (edge_q == TRIG_RISING  && prev < level_q && in_data >= level_q) ||
                          (edge_q == TRIG_FALLING && prev > level_q && in_data <= level_q);
    assign hit          = accept && state == ST_WAIT_TRIG && (force_pend || (prev_valid && crossed));
    assign rd_phys      = frame_start + rd_addr;

    sample_ram #(.DATA_SIZE(DATA_SIZE), .ADDR_W(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (accept),
        .waddr (wr_ptr),
        .din   (in_data),
        .raddr (rd_phys),
        .dout  (rd_data)
    );

    // next-state, counters, trigger bookkeeping; abort overrides everything
    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        cnt_n         = cnt;
        pretrig_n     = pretrig_q;
        level_n       = level_q;
        edge_n        = edge_q;
        prev_n        = prev;
        prev_valid_n  = prev_valid;
        force_pend_n  = force_pend;
        triggered_n   = triggered;
        frame_start_n = frame_start;
        if (accept) begin
            wr_ptr_n     = wr_ptr + ONE;
            prev_n       = in_data;
            prev_valid_n = 1'b1;
        end
        if (force_trig && (state == ST_PREFILL || state == ST_WAIT_TRIG)) force_pend_n = 1'b1;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_n      = pretrig == '0 ? ST_WAIT_TRIG : ST_PREFILL;
                    wr_ptr_n     = '0;
                    cnt_n        = '0;
                    prev_valid_n = 1'b0;
                    force_pend_n = 1'b0;
                    triggered_n  = 1'b0;
                    pretrig_n    = pretrig;
                    level_n      = trig_level;
                    edge_n       = trig_edge;
                end
            end
            ST_PREFILL: begin
                if (accept) begin
                    cnt_n   = cnt + ONE;
                    state_n = cnt + ONE == pretrig_q ? ST_WAIT_TRIG : ST_PREFILL;
                end
            end
            ST_WAIT_TRIG: begin
                if (hit) begin
                    state_n       = pretrig_q == LAST ? ST_DONE : ST_POST;
                    frame_start_n = wr_ptr - pretrig_q;
                    triggered_n   = 1'b1;
                    force_pend_n  = 1'b0;
                    cnt_n         = '0;
                end
            end
            ST_POST: begin
                if (accept) begin
                    cnt_n   = cnt + ONE;
                    state_n = cnt + ONE == LAST - pretrig_q ? ST_DONE : ST_POST;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort) begin
            state_n      = ST_IDLE;
            triggered_n  = 1'b0;
            force_pend_n = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            cnt         <= '0;
            pretrig_q   <= '0;
            level_q     <= '0;
            edge_q      <= TRIG_RISING;
            prev        <= '0;
            prev_valid  <= 1'b0;
            force_pend  <= 1'b0;
            triggered   <= 1'b0;
            frame_start <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            cnt         <= cnt_n;
            pretrig_q   <= pretrig_n;
            level_q     <= level_n;
            edge_q      <= edge_n;
            prev        <= prev_n;
            prev_valid  <= prev_valid_n;
            force_pend  <= force_pend_n;
            triggered   <= triggered_n;
            frame_start <= frame_start_n;
        end
    end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: randomized and directed checks of scope_capture against a sample-list model
module tb_scope_capture;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          in_valid = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0, trig_edge = 1'b0;
    logic [DW-1:0] in_data = '0, trig_level = '0;
    logic [AW-1:0] pretrig = '0, rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy, triggered, capture_done;
    logic [AW-1:0] frame_start;

    int          total = 0, bad = 0;
    int unsigned stim[$];
    int unsigned got[DEPTH];

    scope_capture #(.DATA_SIZE(DW), .DEPTH_LOG2(AW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .arm(arm), .abort(abort),
        .force_trig(force_trig), .trig_edge(trig_edge), .trig_level(trig_level), .pretrig(pretrig),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .triggered(triggered),
        .capture_done(capture_done), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // index of the trigger sample within stim: first sample after the pre-trigger part that crosses
    // the level with a predecessor, or the first waiting sample after a force pulse
    function automatic int find_trig(int pre, int unsigned lvl, bit edg, int force_k);
        int forced;
        forced = force_k < 0 ? -1 : (force_k < pre ? pre : force_k + 1);
        for (int i = pre; i < stim.size(); i++) begin
            if (i == forced) return i;
            if (i > 0 && (edg ? (stim[i-1] > lvl && stim[i] <= lvl) : (stim[i-1] < lvl && stim[i] >= lvl)))
                return i;
        end
        return -1;
    endfunction

    // arm, then stream stim with 1-of-gap strobes until capture_done or the budget runs out
    task automatic drive(input int pre, input int unsigned lvl, input bit edg, input int gap,
                         input int force_k, input int rearm_k,
                         output int acc_done, output bit on_strobe, output bit busy_ok);
        int k;
        bit v;
        k = 0; acc_done = -1; on_strobe = 0; busy_ok = 0;
        pretrig = AW'(pre); trig_level = DW'(lvl); trig_edge = edg; arm = 1; in_valid = 0;
        tick();
        arm = 0;
        for (int c = 0; c < 1000 && k < stim.size(); c++) begin
            v = (c % gap) == 0;
            in_valid = v;
            in_data = v ? DW'(stim[k]) : DW'($urandom);
            force_trig = v && k == force_k;
            arm = v && k == rearm_k;
            tick();
            if (v) k++;
            if (capture_done) begin
                acc_done = k; on_strobe = v; busy_ok = !busy;
                break;
            end
        end
        in_valid = 0; force_trig = 0; arm = 0;
    endtask

    task automatic read_frame();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            tick();
            got[a] = rd_data;
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        tick(); tick();
        total += 5;
        if (rd_data !== '0)      begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (triggered !== 1'b0)  begin bad++; $display("FAIL reset_triggered got=%0b exp=0", triggered); end
        if (capture_done !== 0)  begin bad++; $display("FAIL reset_done got=%0b exp=0", capture_done); end
        if (frame_start !== '0)  begin bad++; $display("FAIL reset_frame_start got=%0d exp=0", frame_start); end
        rstn = 1;
        tick();
    endtask

    task automatic test_rising(input int gap);
        int t, acc; bit strobe, bz;
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(i * 100);
        t = find_trig(4, 1050, 0, -1);
        drive(4, 1050, 0, gap, -1, -1, acc, strobe, bz);
        total += 5;
        if (acc !== 23 || acc !== t + DEPTH - 4) begin bad++; $display("FAIL rising_done_at gap=%0d got=%0d exp=%0d", gap, acc, t + DEPTH - 4); end
        if (strobe !== 1'b1)     begin bad++; $display("FAIL rising_done_on_strobe gap=%0d got=%0b exp=1", gap, strobe); end
        if (bz !== 1'b1)         begin bad++; $display("FAIL rising_busy_fall gap=%0d got=%0b exp=1", gap, bz); end
        if (triggered !== 1'b1)  begin bad++; $display("FAIL rising_triggered gap=%0d got=%0b exp=1", gap, triggered); end
        if (frame_start !== 7)   begin bad++; $display("FAIL rising_frame_start gap=%0d got=%0d exp=7", gap, frame_start); end
        read_frame();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (got[a] !== 700 + 100 * a) begin bad++; $display("FAIL rising_rd gap=%0d addr=%0d got=%0d exp=%0d", gap, a, got[a], 700 + 100 * a); end
        end
        total++;
        if (got[4] !== 1100) begin bad++; $display("FAIL rising_trig_sample got=%0d exp=1100", got[4]); end
    endtask

    task automatic test_falling();
        int t, acc; bit strobe, bz;
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(3000 - 100 * i);
        t = find_trig(0, 2500, 1, -1);
        drive(0, 2500, 1, 1, -1, -1, acc, strobe, bz);
        total += 2;
        if (acc !== 21 || acc !== t + DEPTH) begin bad++; $display("FAIL falling_done_at got=%0d exp=21", acc); end
        if (frame_start !== 5)  begin bad++; $display("FAIL falling_frame_start got=%0d exp=5", frame_start); end
        read_frame();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (got[a] !== 2500 - 100 * a) begin bad++; $display("FAIL falling_rd addr=%0d got=%0d exp=%0d", a, got[a], 2500 - 100 * a); end
        end
        // first sample equals the level with a stale higher sample left over: must not trigger
        stim.delete();
        stim.push_back(900); stim.push_back(800); stim.push_back(1000);
        for (int j = 0; j < 20; j++) stim.push_back(900 - 10 * j);
        t = find_trig(0, 900, 1, -1);
        drive(0, 900, 1, 1, -1, -1, acc, strobe, bz);
        total += 3;
        if (acc !== 19 || acc !== t + DEPTH) begin bad++; $display("FAIL noprior_done_at got=%0d exp=19", acc); end
        if (frame_start !== 3)  begin bad++; $display("FAIL noprior_frame_start got=%0d exp=3", frame_start); end
        read_frame();
        if (got[0] !== 900)     begin bad++; $display("FAIL noprior_rd0 got=%0d exp=900", got[0]); end
    endtask

    task automatic test_force();
        int t, acc; bit strobe, bz;
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(500);
        t = find_trig(2, 1000, 0, 0);
        drive(2, 1000, 0, 1, 0, -1, acc, strobe, bz);
        total += 3;
        if (acc !== 16 || t !== 2) begin bad++; $display("FAIL force_done_at got=%0d exp=16", acc); end
        if (triggered !== 1'b1)    begin bad++; $display("FAIL force_triggered got=%0b exp=1", triggered); end
        if (frame_start !== 0)     begin bad++; $display("FAIL force_frame_start got=%0d exp=0", frame_start); end
        read_frame();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (got[a] !== 500) begin bad++; $display("FAIL force_rd addr=%0d got=%0d exp=500", a, got[a]); end
        end
    endtask

    task automatic test_abort();
        int acc; bit strobe, bz;
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(i * 100);
        pretrig = 4; trig_level = 1050; trig_edge = 0; arm = 1;
        tick();
        arm = 0;
        for (int k = 0; k < 14; k++) begin
            in_valid = 1; in_data = DW'(stim[k]);
            tick();
        end
        in_valid = 0;
        total += 2;
        if (triggered !== 1'b1) begin bad++; $display("FAIL abort_pre_triggered got=%0b exp=1", triggered); end
        if (busy !== 1'b1)      begin bad++; $display("FAIL abort_pre_busy got=%0b exp=1", busy); end
        abort = 1;
        tick();
        abort = 0;
        total += 3;
        if (busy !== 1'b0)         begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        if (triggered !== 1'b0)    begin bad++; $display("FAIL abort_triggered got=%0b exp=0", triggered); end
        if (capture_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", capture_done); end
        arm = 1; abort = 1;
        tick();
        arm = 0; abort = 0;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_arm got=%0b exp=0", busy); end
        drive(4, 1050, 0, 1, -1, -1, acc, strobe, bz);
        read_frame();
        total += 2;
        if (acc !== 23)      begin bad++; $display("FAIL rearm_done_at got=%0d exp=23", acc); end
        if (got[15] !== 2200) begin bad++; $display("FAIL rearm_rd15 got=%0d exp=2200", got[15]); end
    endtask

    task automatic test_arm_busy();
        int acc; bit strobe, bz;
        drive(4, 1050, 0, 2, -1, 8, acc, strobe, bz);
        read_frame();
        total += 3;
        if (acc !== 23)       begin bad++; $display("FAIL armbusy_done_at got=%0d exp=23", acc); end
        if (got[0] !== 700)   begin bad++; $display("FAIL armbusy_rd0 got=%0d exp=700", got[0]); end
        if (got[15] !== 2200) begin bad++; $display("FAIL armbusy_rd15 got=%0d exp=2200", got[15]); end
        arm = 1;
        tick();
        arm = 0;
        total += 2;
        if (capture_done !== 1'b0) begin bad++; $display("FAIL rearm_done_clear got=%0b exp=0", capture_done); end
        if (busy !== 1'b1)         begin bad++; $display("FAIL rearm_busy got=%0b exp=1", busy); end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_reset_mid();
        pretrig = 0; trig_level = 5000; trig_edge = 0; arm = 1;
        tick();
        arm = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; in_data = 100;
            tick();
        end
        in_valid = 0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy got=%0b exp=1", busy); end
        rstn = 0;
        tick();
        total += 5;
        if (rd_data !== '0)        begin bad++; $display("FAIL midreset_rd_data got=%0d exp=0", rd_data); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
        if (triggered !== 1'b0)    begin bad++; $display("FAIL midreset_triggered got=%0b exp=0", triggered); end
        if (capture_done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%0b exp=0", capture_done); end
        if (frame_start !== '0)    begin bad++; $display("FAIL midreset_frame_start got=%0d exp=0", frame_start); end
        rstn = 1;
        tick();
    endtask

    task automatic test_random();
        int pre, gap, fk, t, acc; int unsigned lvl; bit edg, strobe, bz;
        for (int it = 0; it < 8; it++) begin
            pre = it == 0 ? 15 : int'($urandom_range(0, 15));
            edg = 1'($urandom_range(0, 1));
            lvl = $urandom_range(40, 215);
            gap = $urandom_range(1, 3);
            fk = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 20)) : -1;
            t = -1;
            for (int attempt = 0; attempt < 20 && (t < 0 || t + DEPTH - pre > 64); attempt++) begin
                stim.delete();
                for (int i = 0; i < 64; i++) stim.push_back($urandom_range(0, 255));
                t = find_trig(pre, lvl, edg, fk);
            end
            if (t < 0 || t + DEPTH - pre > 64) begin
                fk = 0;
                t = find_trig(pre, lvl, edg, fk);
            end
            drive(pre, lvl, edg, gap, fk, -1, acc, strobe, bz);
            total += 4;
            if (acc !== t + DEPTH - pre) begin bad++; $display("FAIL rand_done_at it=%0d got=%0d exp=%0d", it, acc, t + DEPTH - pre); end
            if (strobe !== 1'b1)         begin bad++; $display("FAIL rand_done_on_strobe it=%0d got=%0b exp=1", it, strobe); end
            if (triggered !== 1'b1)      begin bad++; $display("FAIL rand_triggered it=%0d got=%0b exp=1", it, triggered); end
            if (frame_start !== AW'((t - pre) % DEPTH)) begin bad++; $display("FAIL rand_frame_start it=%0d got=%0d exp=%0d", it, frame_start, (t - pre) % DEPTH); end
            read_frame();
            for (int a = 0; a < DEPTH; a++) begin
                total++;
                if (t >= 0 && got[a] !== stim[t - pre + a]) begin bad++; $display("FAIL rand_rd it=%0d addr=%0d got=%0d exp=%0d", it, a, got[a], stim[t - pre + a]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising(1);
        test_falling();
        test_force();
        test_rising(3);
        test_abort();
        test_arm_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scope_capture.md
# scope_capture

Triggered acquisition buffer that sits directly downstream of the FIR filter stage. It consumes the filtered sample stream (`result`/`done`) and detects a level/edge trigger or a forced trigger. It stores one frame of 2^DEPTH_LOG2 samples, with a programmable pre-trigger count, in an internal circular RAM. Once the frame is complete, the processor side reads it out by frame-relative address.

## Interface
- DATA_SIZE, 16, sample width; matches the filter output width.
- DEPTH_LOG2, 10, log2 of the frame length (DEPTH = 1024).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample strobe (filter `done`); level-sensitive, one sample accepted per cycle high.
- in_data  in  DATA_SIZE  sample (filter `result`), unsigned.
- arm  in  1  pulse; starts a capture from IDLE or DONE.
- abort  in  1  pulse; returns to IDLE from any state.
- force_trig  in  1  pulse; forces a trigger.
- trig_edge  in  1  0 = rising, 1 = falling; latched on arm.
- trig_level  in  DATA_SIZE  trigger threshold; latched on arm.
- pretrig  in  DEPTH_LOG2  samples kept before the trigger sample; latched on arm.
- rd_addr  in  DEPTH_LOG2  frame-relative read address (0 = oldest sample).
- rd_data  out  DATA_SIZE  read data; reset 0.
- busy  out  1  state is PREFILL, WAIT_TRIG or POST; reset 0.
- triggered  out  1  trigger accepted in the current capture; reset 0.
- capture_done  out  1  frame complete; reset 0.
- frame_start  out  DEPTH_LOG2  physical RAM address of frame index 0; reset 0.

## Operation
- States:
  - IDLE: no writes.
  - PREFILL: write until `pretrig` samples are stored.
  - WAIT_TRIG: write continuously, wrapping, and evaluate the trigger.
  - POST: write the remaining DEPTH-1-pretrig samples.
  - DONE: hold the frame.
- Transitions:
  - IDLE/DONE + arm → PREFILL, or → WAIT_TRIG if pretrig = 0. Clears triggered, capture_done, wr_ptr, cnt and prev_valid.
  - PREFILL → WAIT_TRIG on the accepted sample that makes cnt = pretrig.
  - WAIT_TRIG → POST on the accepted trigger sample, or → DONE directly if pretrig = DEPTH-1.
  - POST → DONE on the last accepted sample.
  - Any state + abort → IDLE; triggered and capture_done are cleared. abort beats arm. arm is ignored while busy.
- Write: each accepted sample goes to mem[wr_ptr], then wr_ptr += 1 mod DEPTH.
- Trigger compare, unsigned, on the accepted sample in WAIT_TRIG:
  - rising: prev < level && cur >= level.
  - falling: prev > level && cur <= level.
  - Requires prev_valid, which is set by any accepted sample after arm.
- force_trig:
  - Latched as force_pend in PREFILL or WAIT_TRIG; ignored in IDLE, POST and DONE.
  - Makes the next accepted WAIT_TRIG sample the trigger regardless of prev_valid.
  - Cleared on use, arm, abort and reset.
- On trigger: frame_start ← (wr_ptr - pretrig) mod DEPTH, using the trigger sample's wr_ptr. triggered ← 1.
- Read: rd_data ← mem[(frame_start + rd_addr) mod DEPTH]. Reads are legal in any state but contents are defined only in DONE.
- Modes that hold `done` constantly high yield one sample per clock; this is supported.

## Timing
- Sample accepted at the clk edge where in_valid = 1; it is written the same edge.
- triggered and frame_start update on the edge of the trigger sample, so they are visible the next cycle.
- capture_done rises on the edge of the final write and stays high until arm, abort or reset.
- busy falls the same cycle capture_done rises.
- rd_data latency: 1 cycle from rd_addr (registered BRAM read).
- Samples per capture after arm: pretrig + (cycles waiting) + 1 + (DEPTH-1-pretrig) accepted strobes.
- Reset mid-capture: all outputs and state go to their reset values on that edge; RAM contents are don't-care.

## Structure
- Shared include/package `scope_pkg`:
  - state encodings (IDLE = 0, PREFILL = 1, WAIT_TRIG = 2, POST = 3, DONE = 4, 3-bit);
  - TRIG_RISING = 0, TRIG_FALLING = 1.
- Sub-module `sample_ram`:
  - simple dual-port, DEPTH x DATA_SIZE;
  - write port (we, waddr, din), registered read port (raddr, dout);
  - inferable as BRAM.
- Top level holds the FSM, counters, trigger compare and address arithmetic.

## Test plan
Bench settings for all scenarios: DEPTH_LOG2 = 4, in_valid every cycle.
- Rising trigger: pretrig = 4, level = 1050, ramp 0, 100, 200, … → trigger on 1100. capture_done after 2200 is written. Reads 0..15 return 700..2200 in steps of 100; rd_addr 4 = 1100.
- Falling trigger: pretrig = 0, down-ramp 3000, 2900, …, level = 2500 → trigger on 2500. Frame = 2500..1000. A sample exactly equal to the level with no prior sample does not trigger.
- Force: constant data 500, level 1000, force_trig pulsed during PREFILL (pretrig = 2) → trigger on the 1st WAIT_TRIG sample. Frame is all 500, triggered = 1.
- Gapped strobe: in_valid 1-of-3 cycles, rising test as above → identical frame contents. capture_done rises exactly on the final strobe edge.
- Abort and re-arm: abort during POST → busy = 0, triggered = 0 next cycle. Then arm together with abort → stays IDLE. A later arm → normal capture.
- Reset: rstn = 0 during WAIT_TRIG → all outputs 0 next cycle. arm is ignored while busy; a re-arm from DONE clears capture_done.
